// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - lockstep monitor shared types, register map and compare helpers
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_COUNT  = 2'd2;
  localparam logic [1:0] ADR_LAST   = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam int STAT_STATE_LSB   = 0;
  localparam int STAT_FAULT_BIT   = 2;
  localparam int STAT_CMP_ERR_BIT = 3;
  localparam int STAT_STREAK_LSB  = 4;

  localparam int STREAK_W = 4;
  localparam int LAST_W   = 10;

  // Field order gives the LAST register layout {alu1, alu2, carry1, carry2}.
  typedef struct packed {
    logic [3:0] alu1;
    logic [3:0] alu2;
    logic       carry1;
    logic       carry2;
  } capture_t;

  function automatic logic is_mismatch(input capture_t s);
    return (s.alu1 != s.alu2) || (s.carry1 != s.carry2);
  endfunction

  function automatic logic is_cmp_err(input capture_t s, input logic [3:0] cmp_x,
                                      input logic cmp_y);
    return (cmp_x != (s.alu1 ^ s.alu2)) || (cmp_y != (s.carry1 ^ s.carry2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lockstep_monitor.sv
// rtl/lockstep_monitor.sv - dual-ALU lockstep checker with Wishbone status/control
module lockstep_monitor
  import lockstep_pkg::*;
#(
  parameter int THRESH = 3,
  parameter int CNT_W  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        sample_i,
  input  logic [3:0]  alu_out1_i,
  input  logic [3:0]  alu_out2_i,
  input  logic        carry1_i,
  input  logic        carry2_i,
  input  logic [3:0]  cmp_x_i,
  input  logic        cmp_y_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        fault_o,
  output logic        cmp_err_o
);

  // Reset asserts immediately, releases two clocks after wb_rst_ni rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic        ack_q;
  logic [31:0] dat_q;
  logic        en_q;
  logic        clr_q;
  logic        wb_req;
  logic        wb_wr_ctrl;
  logic [31:0] rdata;

  capture_t            smp_data_q;
  logic [3:0]          cmp_x_q;
  logic                cmp_y_q;
  logic                smp_q;
  state_e              state_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                cmp_err_q;
  logic                captured_q;
  capture_t            last_q;
  logic                mis;
  logic                chk;
  logic                active;
  logic [CNT_W-1:0]    smp_cnt;
  logic [CNT_W-1:0]    mis_cnt;
  logic                unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:2]};

  assign wb_req     = wbs_stb_i && wbs_cyc_i && !ack_q;
  assign wb_wr_ctrl = wb_req && wbs_we_i && (wbs_adr_i[3:2] == ADR_CTRL);

  always_comb begin
    rdata = '0;
    unique case (wbs_adr_i[3:2])
      ADR_CTRL: begin
        rdata[CTRL_EN_BIT] = en_q;
      end
      ADR_STATUS: begin
        rdata[STAT_STATE_LSB +: 2]         = state_q;
        rdata[STAT_FAULT_BIT]              = fault_o;
        rdata[STAT_CMP_ERR_BIT]            = cmp_err_q;
        rdata[STAT_STREAK_LSB +: STREAK_W] = streak_q;
      end
      ADR_COUNT: begin
        rdata[2*CNT_W-1:0] = {mis_cnt, smp_cnt};
      end
      ADR_LAST: begin
        rdata[LAST_W-1:0] = last_q;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      en_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      ack_q <= wb_req;
      dat_q <= (wb_req && !wbs_we_i) ? rdata : '0;
      clr_q <= wb_wr_ctrl && wbs_dat_i[CTRL_CLR_BIT];
      if (wb_wr_ctrl) begin
        en_q <= wbs_dat_i[CTRL_EN_BIT];
      end
    end
  end

  // A sample arriving while a clear is pending is dropped so the clear wins.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      smp_q      <= 1'b0;
      smp_data_q <= '0;
      cmp_x_q    <= '0;
      cmp_y_q    <= 1'b0;
    end else begin
      smp_q <= sample_i && !clr_q;
      if (sample_i) begin
        smp_data_q <= '{alu1: alu_out1_i, alu2: alu_out2_i,
                        carry1: carry1_i, carry2: carry2_i};
        cmp_x_q    <= cmp_x_i;
        cmp_y_q    <= cmp_y_i;
      end
    end
  end

  assign mis      = is_mismatch(smp_data_q);
  assign chk      = is_cmp_err(smp_data_q, cmp_x_q, cmp_y_q);
  assign active   = smp_q && (state_q != ST_IDLE) && !clr_q;
  assign streak_d = streak_q + 1'b1;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      streak_q   <= '0;
      cmp_err_q  <= 1'b0;
      captured_q <= 1'b0;
      last_q     <= '0;
    end else if (clr_q) begin
      state_q    <= en_q ? ST_RUN : ST_IDLE;
      streak_q   <= '0;
      cmp_err_q  <= 1'b0;
      captured_q <= 1'b0;
      last_q     <= '0;
    end else begin
      if (active && chk) begin
        cmp_err_q <= 1'b1;
      end
      if (active && mis && !captured_q) begin
        last_q     <= smp_data_q;
        captured_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (en_q) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en_q) begin
            state_q <= ST_IDLE;
          end else if (smp_q && mis) begin
            streak_q <= STREAK_W'(1);
            state_q  <= (THRESH == 1) ? ST_FAULT : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (!en_q) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
          end else if (smp_q && mis) begin
            streak_q <= streak_d;
            if (streak_d == STREAK_W'(THRESH)) begin
              state_q <= ST_FAULT;
            end
          end else if (smp_q) begin
            streak_q <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (rst_n),
    .inc_i  (active),
    .clr_i  (clr_q),
    .cnt_o  (smp_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mismatch_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (rst_n),
    .inc_i  (active && mis),
    .clr_i  (clr_q),
    .cnt_o  (mis_cnt)
  );

  assign fault_o   = (state_q == ST_FAULT);
  assign cmp_err_o = cmp_err_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_lockstep_monitor.sv
// tb/tb_lockstep_monitor.sv - directed vector bench for lockstep_monitor
module tb_lockstep_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample;
  logic [3:0]  alu1, alu2, cmp_x;
  logic        c1, c2, cmp_y;
  logic        stb, cyc, we;
  logic [31:0] adr, wdat;
  logic        ack1, ack2;
  logic [31:0] dat1, dat2;
  logic        fault1, fault2, cerr1, cerr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lockstep_monitor #(.THRESH(3), .CNT_W(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .sample_i(sample),
    .alu_out1_i(alu1), .alu_out2_i(alu2), .carry1_i(c1), .carry2_i(c2),
    .cmp_x_i(cmp_x), .cmp_y_i(cmp_y),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack1), .wbs_dat_o(dat1), .fault_o(fault1), .cmp_err_o(cerr1)
  );

  lockstep_monitor #(.THRESH(1), .CNT_W(4)) u_dut_small (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .sample_i(sample),
    .alu_out1_i(alu1), .alu_out2_i(alu2), .carry1_i(c1), .carry2_i(c2),
    .cmp_x_i(cmp_x), .cmp_y_i(cmp_y),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack2), .wbs_dat_o(dat2), .fault_o(fault2), .cmp_err_o(cerr2)
  );

  typedef struct {
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        k1;
    logic        k2;
    logic [31:0] exp_status;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [3:0] a1, input logic [3:0] a2, input logic k1,
                     input logic k2, input logic [3:0] x, input logic y);
    alu1 = a1; alu2 = a2; c1 = k1; c2 = k2; cmp_x = x; cmp_y = y;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic smp_ok(input logic [3:0] a1, input logic [3:0] a2, input logic k1,
                        input logic k2);
    smp(a1, a2, k1, k2, a1 ^ a2, k1 ^ k2);
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic with_mis, output logic [31:0] r1, output logic [31:0] r2);
    bit got;
    got = 1'b0;
    r1 = '0;
    r2 = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    if (with_mis) begin
      alu1 = 4'hA; alu2 = 4'h5; c1 = 1'b0; c2 = 1'b0; cmp_x = 4'hF; cmp_y = 1'b0;
      sample = 1'b1;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      sample = 1'b0;
      if (ack1) begin
        got = 1'b1;
        r1 = dat1;
        r2 = dat2;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles");
    end
    tick();
    tick();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r1, output logic [31:0] r2);
    wb(1'b0, a, '0, 1'b0, r1, r2);
  endtask

  task automatic wr(input logic [31:0] d, input logic with_mis);
    logic [31:0] r1, r2;
    wb(1'b1, 32'h0, d, with_mis, r1, r2);
  endtask

  initial begin
    logic [31:0] r1, r2;
    int          acks;

    // {a1, a2, c1, c2} sequence: mis, mis, clean, mis, mis, mis with THRESH=3
    vecs[0] = '{4'h3, 4'h1, 1'b0, 1'b0, 32'h12, 1'b0};
    vecs[1] = '{4'h7, 4'h7, 1'b1, 1'b0, 32'h22, 1'b0};
    vecs[2] = '{4'h9, 4'h9, 1'b1, 1'b1, 32'h01, 1'b0};
    vecs[3] = '{4'hF, 4'h0, 1'b0, 1'b0, 32'h12, 1'b0};
    vecs[4] = '{4'h4, 4'h6, 1'b1, 1'b1, 32'h22, 1'b0};
    vecs[5] = '{4'h8, 4'h8, 1'b0, 1'b1, 32'h37, 1'b1};

    rst_n = 1'b0; sample = 1'b0;
    alu1 = '0; alu2 = '0; c1 = 1'b0; c2 = 1'b0; cmp_x = '0; cmp_y = 1'b0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    repeat (3) tick();
    check("reset_fault", {31'b0, fault1}, 32'h0);
    check("reset_cmp_err", {31'b0, cerr1}, 32'h0);
    check("reset_ack", {31'b0, ack1}, 32'h0);
    check("reset_dat", dat1, 32'h0);
    check("reset_small_flags", {30'b0, fault2, cerr2}, 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();
    rd(32'h4, r1, r2); check("reset_status", r1, 32'h0);
    rd(32'h0, r1, r2); check("reset_ctrl", r1, 32'h0);

    // IDLE ignores samples, including comparator errors
    smp(4'h3, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
    tick(); tick();
    rd(32'h8, r1, r2); check("idle_count", r1, 32'h0);
    check("idle_cmp_err", {31'b0, cerr1}, 32'h0);

    wr(32'h1, 1'b0);
    rd(32'h4, r1, r2); check("en_status_run", r1, 32'h1);
    rd(32'h0, r1, r2); check("en_ctrl_readback", r1, 32'h1);

    for (int i = 0; i < 10; i++) smp_ok(4'h5, 4'h5, 1'b0, 1'b0);
    tick(); tick();
    rd(32'h8, r1, r2);
    check("clean_count", r1, 32'h0000_000A);
    check("clean_count_small", r2, 32'h0000_000A);
    rd(32'h4, r1, r2); check("clean_status", r1, 32'h1);
    check("clean_fault", {31'b0, fault1}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      smp_ok(vecs[i].a1, vecs[i].a2, vecs[i].k1, vecs[i].k2);
      tick(); tick();
      rd(32'h4, r1, r2);
      check($sformatf("vec%0d_status", i), r1, vecs[i].exp_status);
      check($sformatf("vec%0d_fault", i), {31'b0, fault1}, {31'b0, vecs[i].exp_fault});
    end
    rd(32'h8, r1, r2);
    check("streak_count", r1, 32'h0005_0010);
    check("streak_count_small_sat", r2, 32'h0000_005F);
    rd(32'hC, r1, r2);
    check("streak_last", r1, 32'h0000_00C4);
    check("streak_last_small", r2, 32'h0000_00C4);
    check("streak_cmp_err", {31'b0, cerr1}, 32'h0);

    // FAULT ignores en=0 and holds until clr
    wr(32'h0, 1'b0);
    rd(32'h4, r1, r2); check("fault_hold_en0", r1, 32'h37);
    check("fault_hold_pin", {31'b0, fault1}, 32'h1);

    wr(32'h3, 1'b0);
    rd(32'h4, r1, r2); check("clr_status", r1, 32'h1);
    rd(32'h8, r1, r2); check("clr_count", r1, 32'h0);
    rd(32'hC, r1, r2); check("clr_last", r1, 32'h0);

    smp(4'h3, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
    check("cmp_err_latency_pre", {31'b0, cerr1}, 32'h0);
    tick();
    check("cmp_err_set", {31'b0, cerr1}, 32'h1);
    tick();
    wr(32'h3, 1'b0);
    check("cmp_err_cleared", {31'b0, cerr1}, 32'h0);
    rd(32'h8, r1, r2); check("cmp_err_clr_count", r1, 32'h0);

    smp_ok(4'h2, 4'h2, 1'b1, 1'b1);
    tick(); tick();
    wr(32'h3, 1'b1);
    rd(32'h8, r1, r2); check("clr_vs_sample_count", r1, 32'h0);
    rd(32'h4, r1, r2); check("clr_vs_sample_status", r1, 32'h1);
    rd(32'hC, r1, r2); check("clr_vs_sample_last", r1, 32'h0);

    for (int i = 0; i < 20; i++) smp_ok(4'(i), 4'(i) ^ 4'h1, 1'b0, 1'b0);
    tick(); tick();
    rd(32'h8, r1, r2);
    check("sat_count_wide", r1, 32'h0014_0014);
    check("sat_count_small", r2, 32'h0000_00FF);
    rd(32'h4, r1, r2);
    check("sat_status_wide", r1, 32'h37);
    check("thresh1_status_small", r2, 32'h17);

    // Back-to-back accesses: held strobe gives one ack every two cycles
    acks = 0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack1) acks++;
      if (i == 1) check("b2b_dat_idle_zero", dat1, 32'h0);
    end
    stb = 1'b0; cyc = 1'b0;
    check("b2b_ack_count", 32'(acks), 32'd2);
    tick(); tick();

    // Reset asserted during the ack cycle of a FAULT status read
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4;
    tick();
    check("rst_mid_ack_seen", {31'b0, ack1}, 32'h1);
    check("rst_mid_status", dat1, 32'h37);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'b0, ack1}, 32'h0);
    check("rst_mid_dat", dat1, 32'h0);
    check("rst_mid_fault", {31'b0, fault1}, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    rd(32'h4, r1, r2); check("rst_after_status", r1, 32'h0);
    rd(32'h0, r1, r2); check("rst_after_ctrl", r1, 32'h0);
    rd(32'h8, r1, r2); check("rst_after_count", r1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
